// File: rtl/deserializador_fifo.sv
// Serial-to-parallel receiver: assembles WIDTH-bit words from a qualified bit stream into a DEPTH-word FIFO.
// Optional even-parity framing is enabled by defining DESERIALIZADOR_PARITY_EN.
module deserializador_fifo #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int MSB_FIRST = 0
) (
  input  logic                       clock_100KHz,
  input  logic                       reset,
  input  logic                       write_in,
  input  logic                       data_in,
  input  logic                       ack_in,
  output logic [WIDTH-1:0]           data_out,
  output logic                       data_ready,
  output logic                       status_out,
  output logic [$clog2(DEPTH+1)-1:0] level_out,
  output logic                       overflow_out,
  output logic                       parity_err_out
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

`ifdef DESERIALIZADOR_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, RECV = 2'd1, PAR = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, RECV = 2'd1} state_t;
`endif

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_word;
  logic             w_capture;
  logic             w_push_req;
  logic [WIDTH-1:0] w_push_data;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [LVL_W-1:0] r_level;
  logic             r_ovf;
  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;

  function automatic logic [CNT_W-1:0] f_bit_idx(input logic [CNT_W-1:0] cnt);
    if (MSB_FIRST != 0) return CNT_LAST - cnt;
    else                return cnt;
  endfunction

  // Word under construction with the current bit merged in
  always_comb begin
    w_word = r_shift;
    w_word[f_bit_idx(r_cnt)] = data_in;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (write_in) begin
          w_state_nxt = RECV;
          w_cnt_nxt   = CNT_W'(1);
        end
      end
      RECV: begin
        if (!write_in) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
`ifdef DESERIALIZADOR_PARITY_EN
          w_state_nxt = PAR;
`else
          w_state_nxt = IDLE;
`endif
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_W'(1);
        end
      end
`ifdef DESERIALIZADOR_PARITY_EN
      PAR: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
`endif
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

`ifdef DESERIALIZADOR_PARITY_EN
  logic r_perr;
  logic w_frame_end;
  logic w_par_bad;

  // The data word is complete in r_shift while the parity bit is on data_in
  always_comb begin
    w_capture   = write_in && (r_state != PAR);
    w_frame_end = write_in && (r_state == PAR);
    w_par_bad   = ^{r_shift, data_in};
    w_push_req  = w_frame_end && !w_par_bad;
    w_push_data = r_shift;
  end

  always_ff @(posedge clock_100KHz or negedge reset) begin
    if (!reset)                        r_perr <= 1'b0;
    else if (w_frame_end && w_par_bad) r_perr <= 1'b1;
  end

  assign parity_err_out = r_perr;
`else
  always_comb begin
    w_capture   = write_in;
    w_push_req  = write_in && (r_state == RECV) && (r_cnt == CNT_LAST);
    w_push_data = w_word;
  end

  assign parity_err_out = 1'b0;
`endif

  always_ff @(posedge clock_100KHz or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clock_100KHz) begin
    if (w_capture) r_shift <= w_word;
  end

  // FIFO: a full FIFO still accepts a word when the head is popped on the same edge
  always_comb begin
    w_empty = (r_level == '0);
    w_full  = (r_level == LVL_FULL);
    w_pop   = ack_in && !w_empty;
    w_push  = w_push_req && (!w_full || w_pop);
    w_drop  = w_push_req && w_full && !w_pop;
  end

  always_ff @(posedge clock_100KHz) begin
    if (w_push) r_mem[r_wptr] <= w_push_data;
  end

  always_ff @(posedge clock_100KHz or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
      if (w_drop) r_ovf <= 1'b1;
    end
  end

  assign data_out     = w_empty ? '0 : r_mem[r_rptr];
  assign data_ready   = !w_empty;
  assign status_out   = w_full;
  assign level_out    = r_level;
  assign overflow_out = r_ovf;

endmodule

// File: tb/tb_deserializador_fifo.sv
// Self-checking bench for deserializador_fifo: LSB-first and MSB-first instances share one stimulus stream.
module tb_deserializador_fifo;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int LW = $clog2(D + 1);
`ifdef DESERIALIZADOR_PARITY_EN
  localparam int LAST_EDGE = W;
`else
  localparam int LAST_EDGE = W - 1;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr = 1'b0;
  logic          din = 1'b0;
  logic          ack = 1'b0;
  logic [W-1:0]  data_out, msb_data_out;
  logic          data_ready, msb_ready;
  logic          status_out, msb_status;
  logic [LW-1:0] level_out, msb_level;
  logic          overflow_out, msb_ovf;
  logic          parity_err_out, msb_perr;

  deserializador_fifo #(.WIDTH(W), .DEPTH(D), .MSB_FIRST(0)) u_dut (
    .clock_100KHz(clk), .reset(rst_n), .write_in(wr), .data_in(din), .ack_in(ack),
    .data_out(data_out), .data_ready(data_ready), .status_out(status_out),
    .level_out(level_out), .overflow_out(overflow_out), .parity_err_out(parity_err_out));

  deserializador_fifo #(.WIDTH(W), .DEPTH(D), .MSB_FIRST(1)) u_msb (
    .clock_100KHz(clk), .reset(rst_n), .write_in(wr), .data_in(din), .ack_in(ack),
    .data_out(msb_data_out), .data_ready(msb_ready), .status_out(msb_status),
    .level_out(msb_level), .overflow_out(msb_ovf), .parity_err_out(msb_perr));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;
  logic [W-1:0] exp_q[$];
  bit m_ovf  = 1'b0;
  bit m_perr = 1'b0;

  typedef struct {
    logic [W-1:0] word;
    logic [15:0]  ack_mask;
    int           exp_level;
    bit           exp_full;
    bit           exp_ovf;
    logic [W-1:0] exp_head;
  } vec_t;
  vec_t vecs[5];

  function automatic logic [W-1:0] rev(input logic [W-1:0] x);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = x[W-1-i];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [W-1:0] head;
    head = (exp_q.size() > 0) ? exp_q[0] : '0;
    check({tag, ".ready"},  32'(data_ready),     32'(exp_q.size() > 0));
    check({tag, ".data"},   32'(data_out),       32'(head));
    check({tag, ".level"},  32'(level_out),      32'(exp_q.size()));
    check({tag, ".status"}, 32'(status_out),     32'(exp_q.size() == D));
    check({tag, ".ovf"},    32'(overflow_out),   32'(m_ovf));
    check({tag, ".perr"},   32'(parity_err_out), 32'(m_perr));
    check({tag, ".msb"},    32'(msb_data_out),   32'(rev(head)));
    check({tag, ".msblvl"}, 32'(msb_level),      32'(exp_q.size()));
  endtask

  // One clock edge with the given inputs, then the queue-level FIFO model reacts
  task automatic step(input logic w, input logic d, input logic a,
                      input bit push_req, input logic [W-1:0] pword);
    bit was_full;
    bit popped;
    wr = w; din = d; ack = a;
    was_full = (exp_q.size() == D);
    popped   = 1'b0;
    @(posedge clk);
    #1;
    if (a && exp_q.size() > 0) begin
      void'(exp_q.pop_front());
      popped = 1'b1;
    end
    if (push_req) begin
      if (!was_full || popped) exp_q.push_back(pword);
      else                     m_ovf = 1'b1;
    end
  endtask

  task automatic send_word(input logic [W-1:0] word, input logic [15:0] mask, input bit bad_par);
    for (int i = 0; i < W; i++) begin
`ifdef DESERIALIZADOR_PARITY_EN
      step(1'b1, word[i], mask[i], 1'b0, word);
`else
      step(1'b1, word[i], mask[i], (i == W - 1), word);
`endif
    end
`ifdef DESERIALIZADOR_PARITY_EN
    step(1'b1, (^word) ^ bad_par, mask[W], !bad_par, word);
    if (bad_par) m_perr = 1'b1;
`else
    if (bad_par) m_perr = 1'b1;
`endif
  endtask

  initial begin
    logic [W-1:0] w85;
    logic [W-1:0] wff;
    w85 = 8'h85;
    wff = 8'hFF;
    vecs[0] = '{8'h3C, 16'h0, 2, 1'b0, 1'b0, 8'h85};
    vecs[1] = '{8'hF0, 16'h0, 3, 1'b0, 1'b0, 8'h85};
    vecs[2] = '{8'h5A, 16'h0, 4, 1'b1, 1'b0, 8'h85};
    vecs[3] = '{8'h77, 16'h0, 4, 1'b1, 1'b1, 8'h85};
    vecs[4] = '{8'h99, 16'h1 << LAST_EDGE, 4, 1'b1, 1'b1, 8'h3C};

    #3;
    check_all("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // First word: stream 1,0,1,0,0,0,0,1 and check the one-edge latency
    for (int i = 0; i < W - 1; i++) step(1'b1, w85[i], 1'b0, 1'b0, w85);
    check("lat.pre_ready", 32'(data_ready), 32'd0);
`ifdef DESERIALIZADOR_PARITY_EN
    step(1'b1, w85[W-1], 1'b0, 1'b0, w85);
    step(1'b1, ^w85, 1'b0, 1'b1, w85);
`else
    step(1'b1, w85[W-1], 1'b0, 1'b1, w85);
`endif
    check_all("lat");
    check("lat.lsb", 32'(data_out), 32'h85);
    check("lat.msb", 32'(msb_data_out), 32'hA1);

    // Fill, overflow, and push coincident with pop while full
    for (int i = 0; i < 5; i++) begin
      send_word(vecs[i].word, vecs[i].ack_mask, 1'b0);
      check($sformatf("vec%0d.level", i), 32'(level_out), 32'(vecs[i].exp_level));
      check($sformatf("vec%0d.full", i), 32'(status_out), 32'(vecs[i].exp_full));
      check($sformatf("vec%0d.ovf", i), 32'(overflow_out), 32'(vecs[i].exp_ovf));
      check($sformatf("vec%0d.head", i), 32'(data_out), 32'(vecs[i].exp_head));
      check_all($sformatf("vec%0d", i));
    end

    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, '0);
      check_all($sformatf("drain%0d", i));
    end
    step(1'b0, 1'b0, 1'b1, 1'b0, '0);
    check_all("empty_ack");

    // Asynchronous reset mid-word with two words queued
    send_word(8'hA5, 16'h0, 1'b0);
    send_word(8'hC3, 16'h0, 1'b0);
    check("pre_rst.level", 32'(level_out), 32'd2);
    for (int i = 0; i < 4; i++) step(1'b1, i[0], 1'b0, 1'b0, '0);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    m_ovf  = 1'b0;
    m_perr = 1'b0;
    check("rst.level", 32'(level_out), 32'd0);
    check("rst.ovf", 32'(overflow_out), 32'd0);
    check_all("rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_word(8'h5A, 16'h0, 1'b0);
    check("post_rst.val", 32'(data_out), 32'h5A);
    check_all("post_rst");
    step(1'b0, 1'b0, 1'b1, 1'b0, '0);

    // Abort after three bits, then a full word
    for (int i = 0; i < 3; i++) step(1'b1, wff[i], 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, 1'b0, '0);
    send_word(8'h3C, 16'h0, 1'b0);
    check("abort.val", 32'(data_out), 32'h3C);
    check("abort.level", 32'(level_out), 32'd1);
    check_all("abort");
    step(1'b0, 1'b0, 1'b1, 1'b0, '0);

    // Random words with pops scattered across bit edges
    for (int k = 0; k < 12; k++) begin
      logic [W-1:0] rw;
      logic [15:0]  rm;
      rw = W'($urandom);
      rm = 16'($urandom) & 16'($urandom);
      send_word(rw, rm, 1'b0);
      check_all($sformatf("rnd%0d", k));
    end

`ifdef DESERIALIZADOR_PARITY_EN
    for (int i = 0; i < D + 1; i++) step(1'b0, 1'b0, 1'b1, 1'b0, '0);
    send_word(8'h0F, 16'h0, 1'b1);
    check("par_bad.perr", 32'(parity_err_out), 32'd1);
    check("par_bad.level", 32'(level_out), 32'd0);
    check_all("par_bad");
    send_word(8'h0F, 16'h0, 1'b0);
    check("par_ok.val", 32'(data_out), 32'h0F);
    check_all("par_ok");
`endif

    step(1'b0, 1'b0, 1'b0, 1'b0, '0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule

// File: doc/deserializador_fifo.md
# deserializador_fifo

Parametrised serial-to-parallel receiver that assembles WIDTH-bit words from a one-bit stream qualified by `write_in`. Completed words are queued in a DEPTH-entry FIFO and presented to the consumer through a `data_ready`/`ack_in` handshake. It sits between the serial link and the word consumer as the next generation of the 8-bit single-word deserializer. It adds configurable width, bit order, buffering, abort of partial words and overflow reporting.

## Interface
- `WIDTH`, default 8: word width in bits. Legal range 2..32.
- `DEPTH`, default 4: FIFO depth in words. Must be a power of two, at least 2.
- `MSB_FIRST`, default 0: 0 means the first received bit lands in bit 0; 1 means it lands in bit WIDTH-1.
- `clock_100KHz` in, 1 bit: single clock; all logic is on its rising edge.
- `reset` in, 1 bit: asynchronous, active-low reset.
- `write_in` in, 1 bit: qualifies `data_in` on each clock edge.
- `data_in` in, 1 bit: serial data bit.
- `ack_in` in, 1 bit: consumer pops the head word.
- `data_out` out, WIDTH bits: head word of the FIFO; all zeros when the FIFO is empty.
- `data_ready` out, 1 bit: FIFO is non-empty.
- `status_out` out, 1 bit: FIFO is full (busy); the sender must stop after the current word.
- `level_out` out, $clog2(DEPTH+1) bits: number of stored words.
- `overflow_out` out, 1 bit: sticky flag; set when a completed word is dropped because the FIFO is full.
- `parity_err_out` out, 1 bit: sticky flag; present only with `DESERIALIZADOR_PARITY_EN`.

## Operation
- States:
  - IDLE: no partial word held.
  - RECV: partial word in progress.
  - PAR: expecting the parity bit; exists only with the macro.
- Bit capture:
  - Each edge with `write_in`=1 captures `data_in` into the shift/index position set by `MSB_FIRST` and increments the bit counter.
  - The counter is $clog2(WIDTH) bits wide.
- Transitions:
  - IDLE to RECV on the first sampled bit. That bit is stored; there is no idle wait cycle.
  - RECV to IDLE when bit WIDTH-1 is sampled (word complete). With the macro, RECV goes to PAR instead.
  - PAR to IDLE when the parity bit is sampled.
- Abort: `write_in`=0 while in RECV or PAR discards the partial word. The bit counter returns to 0 and the state returns to IDLE. No flag is raised.
- Push: a completed word is written to the FIFO on the edge that samples its last bit (the parity bit when the macro is enabled).
  - If the FIFO is full and `ack_in` is 0 on that edge, the word is dropped and `overflow_out` is set.
  - If the FIFO is full and `ack_in` is 1 on that edge, the pop and the push both occur and the level is unchanged.
- Pop: `ack_in`=1 with the FIFO non-empty advances the read pointer. `ack_in` on an empty FIFO is ignored.
- Pointers: read and write pointers are $clog2(DEPTH) bits and wrap naturally. Full and empty are derived from `level_out`.
- Clearing sticky flags: `overflow_out` and `parity_err_out` clear only on reset.
- Reset: every output, the pointers, the level, the counter and the state go to 0 / IDLE immediately. A word in progress is lost. FIFO contents need not be cleared, because `data_out` is masked while the FIFO is empty.

## Timing
- Latency: the last bit is sampled on edge N; `data_ready`=1 and `data_out` is valid after edge N (visible in cycle N+1).
- Pop: `ack_in` sampled on edge M; the next word, or zero with `data_ready`=0, is visible after edge M.
- Outputs: `data_ready`, `status_out` and `level_out` are registered or derived from the registered level. None has a combinational path from inputs.
- Throughput: back-to-back words with `write_in` held high are accepted with no gap cycle between words.

## Configuration
- `DESERIALIZADOR_PARITY_EN` defined:
  - One even-parity bit follows the WIDTH data bits.
  - A word whose XOR of data plus parity is 1 is discarded, never pushed, and sets `parity_err_out`.
  - Frame length is WIDTH+1 bits.
- `DESERIALIZADOR_PARITY_EN` undefined:
  - The PAR state is absent and frames are WIDTH bits.
  - `parity_err_out` is tied to 0.

## Test plan
- WIDTH=8, MSB_FIRST=0: stream bits 1,0,1,0,0,0,0,1 -> `data_out`=8'h85 and `data_ready`=1 one cycle after the 8th bit; `level_out`=1.
- MSB_FIRST=1: same stream -> `data_out`=8'hA1.
- DEPTH=4: five back-to-back words with no ack -> `status_out`=1 after the 4th word; the 5th is dropped; `overflow_out`=1; `level_out`=4. A subsequent push coincident with `ack_in` keeps the level at 4 and leaves `overflow_out` sticky.
- `write_in` drops after 3 bits, then a full word 8'h3C is streamed -> only 8'h3C is queued; no flag.
- `reset` asserted mid-word with 2 words queued -> all outputs are 0 the same cycle; after release, a new word is received correctly from bit 0.
- Macro defined: word 8'h0F with parity 1 -> `parity_err_out`=1 and `level_out` unchanged. Word 8'h0F with parity 0 -> queued.
